// File: rtl/xv_pkg.sv
// Shared video/audio definitions: channel count, VRAM address width, bus word types
// and the per-channel register offsets used by the audio register block.
package xv;

  localparam int AUDIO_NCHAN = 4;
  localparam int VRAM_W      = 16;

  typedef logic [VRAM_W-1:0] addr_t;
  typedef logic [15:0]       word_t;

  typedef enum logic [1:0] {
    REG_VOL    = 2'd0,
    REG_PERIOD = 2'd1,
    REG_LENGTH = 2'd2,
    REG_START  = 2'd3
  } chan_reg_e;

endpackage

// File: rtl/audio_chan_regs.sv
// Per-channel audio register file plus global control (enable, interrupt mask/pending).
// Optional interrupt logic is built only when AUDIO_INTR_EN is defined.
module audio_chan_regs #(
  parameter int AUDIO_NCHAN = xv::AUDIO_NCHAN,
  localparam int CHAN_W = (AUDIO_NCHAN > 1) ? $clog2(AUDIO_NCHAN) : 1
) (
  input  logic                              clk,
  input  logic                              reset_i,
  input  logic                              reg_wr_i,
  input  logic                              reg_rd_i,
  input  logic [CHAN_W+1:0]                 reg_addr_i,
  input  logic [15:0]                       reg_data_i,
  output logic [15:0]                       reg_data_o,
  input  logic                              ctrl_wr_i,
  output logic                              audio_enable_o,
  output logic [7*AUDIO_NCHAN-1:0]          audio_vol_l_nchan_o,
  output logic [7*AUDIO_NCHAN-1:0]          audio_vol_r_nchan_o,
  output logic [15*AUDIO_NCHAN-1:0]         audio_period_nchan_o,
  output logic [AUDIO_NCHAN-1:0]            audio_tile_nchan_o,
  output logic [xv::VRAM_W*AUDIO_NCHAN-1:0] audio_start_nchan_o,
  output logic [15*AUDIO_NCHAN-1:0]         audio_len_nchan_o,
  output logic [AUDIO_NCHAN-1:0]            audio_restart_nchan_o,
  input  logic [AUDIO_NCHAN-1:0]            audio_reload_nchan_i,
  output logic [AUDIO_NCHAN-1:0]            audio_ready_o,
  output logic                              audio_intr_o
);
  import xv::*;

  localparam int N     = AUDIO_NCHAN;
  localparam int NSLOT = 2 ** CHAN_W;

  logic [CHAN_W-1:0] sel_chan;
  chan_reg_e         sel_reg;
  word_t             rd_word [NSLOT];
  word_t             ctrl_word;
  logic              enable;

  assign sel_chan = reg_addr_i[CHAN_W+1:2];
  assign sel_reg  = chan_reg_e'(reg_addr_i[1:0]);

  for (genvar c = 0; c < N; c++) begin : g_chan
    localparam logic [CHAN_W-1:0] CIDX = CHAN_W'(c);

    logic       hit;
    logic [6:0] vol_l, vol_r;
    logic [14:0] period, len;
    logic       tile;
    addr_t      start;
    logic       ready, restart;

    assign hit = reg_wr_i && (sel_chan == CIDX);

    always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
        vol_l   <= '0;
        vol_r   <= '0;
        period  <= '0;
        len     <= '0;
        tile    <= 1'b0;
        start   <= '0;
        ready   <= 1'b1;
        restart <= 1'b0;
      end else begin
        restart <= hit && (sel_reg == REG_PERIOD) && reg_data_i[15];
        if (hit) begin
          case (sel_reg)
            REG_VOL: begin
              vol_l <= reg_data_i[14:8];
              vol_r <= reg_data_i[6:0];
            end
            REG_PERIOD: period <= reg_data_i[14:0];
            REG_LENGTH: begin
              len  <= reg_data_i[14:0];
              tile <= reg_data_i[15];
            end
            default: start <= addr_t'(reg_data_i);
          endcase
        end
        // a START write re-arms the channel even if the mixer reloads in the same cycle
        if (hit && (sel_reg == REG_START))
          ready <= 1'b0;
        else if (audio_reload_nchan_i[c])
          ready <= 1'b1;
      end
    end

    always_comb begin
      rd_word[c] = '0;
      case (sel_reg)
        REG_VOL:    rd_word[c] = {1'b0, vol_l, 1'b0, vol_r};
        REG_PERIOD: rd_word[c] = {1'b0, period};
        REG_LENGTH: rd_word[c] = {tile, len};
        default:    rd_word[c] = word_t'(start);
      endcase
    end

    assign audio_vol_l_nchan_o[c*7 +: 7]            = vol_l;
    assign audio_vol_r_nchan_o[c*7 +: 7]            = vol_r;
    assign audio_period_nchan_o[c*15 +: 15]         = period;
    assign audio_len_nchan_o[c*15 +: 15]            = len;
    assign audio_tile_nchan_o[c]                    = tile;
    assign audio_start_nchan_o[c*VRAM_W +: VRAM_W]  = start;
    assign audio_restart_nchan_o[c]                 = restart;
    assign audio_ready_o[c]                         = ready;
  end

  for (genvar c = N; c < NSLOT; c++) begin : g_unused_slot
    assign rd_word[c] = '0;
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i)
      enable <= 1'b0;
    else if (ctrl_wr_i)
      enable <= reg_data_i[0];
  end
  assign audio_enable_o = enable;

`ifdef AUDIO_INTR_EN
  logic [N-1:0] mask, pending, pend_set, pend_clr;
  logic         intr;

  assign pend_set = audio_reload_nchan_i & mask;
  assign pend_clr = ctrl_wr_i ? reg_data_i[N-1:0] : '0;

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      mask    <= '0;
      pending <= '0;
      intr    <= 1'b0;
    end else begin
      if (ctrl_wr_i)
        mask <= reg_data_i[N+7:8];
      pending <= (pending & ~pend_clr) | pend_set;
      intr    <= |(pend_set & ~pending);
    end
  end

  assign ctrl_word    = (word_t'(mask) << 8) | word_t'(pending);
  assign audio_intr_o = intr;
`else
  assign ctrl_word    = '0;
  assign audio_intr_o = 1'b0;
`endif

  // The control word has no address of its own: a read strobe coinciding with a
  // control write returns the pre-write {mask, pending}.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i)
      reg_data_o <= '0;
    else if (reg_rd_i && ctrl_wr_i)
      reg_data_o <= ctrl_word;
    else if (reg_rd_i)
      reg_data_o <= rd_word[sel_chan];
  end

endmodule

// File: tb/tb_audio_chan_regs.sv
// Directed-vector bench for audio_chan_regs (4 channels); interrupt checks need AUDIO_INTR_EN.
module tb_audio_chan_regs;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        reg_wr_i, reg_rd_i, ctrl_wr_i;
  logic [3:0]  reg_addr_i;
  logic [15:0] reg_data_i, reg_data_o;
  logic        audio_enable_o, audio_intr_o;
  logic [27:0] vol_l, vol_r;
  logic [59:0] period, len;
  logic [63:0] start;
  logic [3:0]  tile, restart, reload, ready;

  int tests_run = 0;
  int tests_failed = 0;

  audio_chan_regs #(.AUDIO_NCHAN(N)) dut (
    .clk                  (clk),
    .reset_i              (reset_i),
    .reg_wr_i             (reg_wr_i),
    .reg_rd_i             (reg_rd_i),
    .reg_addr_i           (reg_addr_i),
    .reg_data_i           (reg_data_i),
    .reg_data_o           (reg_data_o),
    .ctrl_wr_i            (ctrl_wr_i),
    .audio_enable_o       (audio_enable_o),
    .audio_vol_l_nchan_o  (vol_l),
    .audio_vol_r_nchan_o  (vol_r),
    .audio_period_nchan_o (period),
    .audio_tile_nchan_o   (tile),
    .audio_start_nchan_o  (start),
    .audio_len_nchan_o    (len),
    .audio_restart_nchan_o(restart),
    .audio_reload_nchan_i (reload),
    .audio_ready_o        (ready),
    .audio_intr_o         (audio_intr_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_reg(input logic [3:0] addr, input logic [15:0] data);
    reg_wr_i = 1'b1; reg_addr_i = addr; reg_data_i = data;
    tick();
    reg_wr_i = 1'b0;
  endtask

  task automatic rd_reg(input logic [3:0] addr);
    reg_rd_i = 1'b1; reg_addr_i = addr;
    tick();
    reg_rd_i = 1'b0;
  endtask

  task automatic wr_ctrl(input logic [15:0] data, input logic rd);
    ctrl_wr_i = 1'b1; reg_rd_i = rd; reg_data_i = data;
    tick();
    ctrl_wr_i = 1'b0; reg_rd_i = 1'b0;
  endtask

  initial begin
    reset_i = 1'b1; reg_wr_i = 0; reg_rd_i = 0; ctrl_wr_i = 0;
    reg_addr_i = '0; reg_data_i = '0; reload = '0;
    #12;
    chk("rst_ready",   64'(ready), 64'hF);
    chk("rst_data",    64'(reg_data_o), 64'h0);
    chk("rst_enable",  64'(audio_enable_o), 64'h0);
    chk("rst_restart", 64'(restart), 64'h0);
    chk("rst_intr",    64'(audio_intr_o), 64'h0);
    chk("rst_vol_l",   64'(vol_l), 64'h0);
    @(negedge clk); reset_i = 1'b0;
    tick();

    // ch1 VOL
    wr_reg(4'b0100, 16'h3F20);
    chk("vol_l_bus", 64'(vol_l), 64'h3F << 7);
    chk("vol_r_bus", 64'(vol_r), 64'h20 << 7);
    rd_reg(4'b0100);
    chk("rd_vol1", 64'(reg_data_o), 64'h3F20);

    // ch2 PERIOD with restart
    wr_reg(4'b1001, 16'h8100);
    chk("restart_on",  64'(restart), 64'b0100);
    chk("period_bus",  64'(period), 64'h100 << 30);
    tick();
    chk("restart_off", 64'(restart), 64'h0);
    rd_reg(4'b1001);
    chk("rd_period2", 64'(reg_data_o), 64'h0100);

    // ch3 LENGTH with tile
    wr_reg(4'b1110, 16'h8005);
    chk("len_bus",  64'(len), 64'h5 << 45);
    chk("tile_bus", 64'(tile), 64'b1000);
    chk("no_restart_len", 64'(restart), 64'h0);
    rd_reg(4'b1110);
    chk("rd_len3", 64'(reg_data_o), 64'h8005);

    // ch0 START then reload
    wr_reg(4'b0011, 16'h1234);
    chk("ready_clr0", 64'(ready), 64'b1110);
    chk("start_bus",  64'(start), 64'h1234);
    reload = 4'b0001; tick(); reload = '0;
    chk("ready_set0", 64'(ready), 64'hF);
    rd_reg(4'b0011);
    chk("rd_start0", 64'(reg_data_o), 64'h1234);

    // START beats reload on ch3
    reload = 4'b1000;
    wr_reg(4'b1111, 16'hBEEF);
    reload = '0;
    chk("start_wins3", 64'(ready), 64'b0111);
    chk("start_bus3",  64'(start), 64'hBEEF_0000_0000_1234);

    // read and write same address in one cycle returns the old value
    reg_rd_i = 1'b1;
    wr_reg(4'b0100, 16'h0102);
    reg_rd_i = 1'b0;
    chk("rd_old", 64'(reg_data_o), 64'h3F20);
    tick(); tick();
    chk("rd_hold", 64'(reg_data_o), 64'h3F20);
    rd_reg(4'b0100);
    chk("rd_new", 64'(reg_data_o), 64'h0102);

    // control
    wr_ctrl(16'h0F01, 1'b0);
    chk("enable_on", 64'(audio_enable_o), 64'h1);
`ifdef AUDIO_INTR_EN
    reload = 4'b0010; tick(); reload = '0;
    chk("intr_pulse", 64'(audio_intr_o), 64'h1);
    wr_ctrl(16'h0F00, 1'b1);
    chk("intr_drop", 64'(audio_intr_o), 64'h0);
    chk("rd_pending", 64'(reg_data_o), 64'h0F02);
    wr_ctrl(16'h0F03, 1'b0);
    wr_ctrl(16'h0F01, 1'b1);
    chk("rd_cleared", 64'(reg_data_o), 64'h0F00);
`else
    reload = 4'b0010; tick(); reload = '0;
    chk("intr_tied", 64'(audio_intr_o), 64'h0);
    wr_ctrl(16'h0F01, 1'b1);
    chk("rd_ctrl_zero", 64'(reg_data_o), 64'h0);
`endif
    wr_ctrl(16'h0000, 1'b0);
    chk("enable_off", 64'(audio_enable_o), 64'h0);

    // restart is independent of enable; reset mid-pulse discards it
    wr_reg(4'b0001, 16'h8007);
    chk("restart_dis", 64'(restart), 64'b0001);
    reset_i = 1'b1;
    #1;
    chk("mid_rst_restart", 64'(restart), 64'h0);
    chk("mid_rst_ready",   64'(ready), 64'hF);
    chk("mid_rst_period",  64'(period), 64'h0);
    chk("mid_rst_start",   64'(start), 64'h0);
    chk("mid_rst_data",    64'(reg_data_o), 64'h0);
    @(negedge clk); reset_i = 1'b0;
    tick();
    chk("post_rst_restart", 64'(restart), 64'h0);
    chk("post_rst_vol", 64'(vol_l), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
